// File: rtl/nfc_command_read_status_poll_if.sv
// ACG primitive request/response bus between the read-status poller and the
// primitive engines (CA-out, data-in).
interface nfc_command_read_status_poll_if #(
    parameter int NumberOfWays = 4
);
    logic [7:0]              oACG_Command;
    logic [2:0]              oACG_CommandOption;
    logic [NumberOfWays-1:0] oACG_TargetWay;
    logic [15:0]             oACG_NumOfData;
    logic                    oACG_CASelect;
    logic [39:0]             oACG_CAData;
    logic [7:0]              iACG_Ready;
    logic [7:0]              iACG_LastStep;
    logic [15:0]             iACG_ReadData;
    logic                    iACG_ReadLast;
    logic                    iACG_ReadValid;

    modport master (
        output oACG_Command,
        output oACG_CommandOption,
        output oACG_TargetWay,
        output oACG_NumOfData,
        output oACG_CASelect,
        output oACG_CAData,
        input  iACG_Ready,
        input  iACG_LastStep,
        input  iACG_ReadData,
        input  iACG_ReadLast,
        input  iACG_ReadValid
    );

    modport slave (
        input  oACG_Command,
        input  oACG_CommandOption,
        input  oACG_TargetWay,
        input  oACG_NumOfData,
        input  oACG_CASelect,
        input  oACG_CAData,
        output iACG_Ready,
        output iACG_LastStep,
        output iACG_ReadData,
        output iACG_ReadLast,
        output iACG_ReadValid
    );
endinterface

// File: rtl/nfc_command_read_status_poll.sv
// NAND read-status (70h / 78h) command sequencer with optional ready polling,
// poll timeout and post-status recovery delay.
module nfc_command_read_status_poll #(
    parameter int          NumberOfWays = 4,
    parameter logic [5:0]  CommandID    = 6'b001000,
    parameter int          WaitCycles   = 12,
    parameter int          PollInterval = 16,
    parameter int          MaxPolls     = 1024,
    parameter logic [7:0]  ReadyMask    = 8'h40
) (
    input  logic                    iSystemClock,
    input  logic                    iReset_n,
    input  logic [5:0]              iOpcode,
    input  logic [4:0]              iTargetID,
    input  logic                    iCMDValid,
    output logic                    oCMDReady,
    input  logic [NumberOfWays-1:0] iWaySelect,
    input  logic [23:0]             iRowAddress,
    output logic                    oStart,
    output logic                    oLastStep,
    output logic [23:0]             oStatus,
    output logic                    oStatusValid,
    output logic                    oTimeout,
    nfc_command_read_status_poll_if.master acg
);

    localparam logic [15:0] WAIT_LAST_C = 16'(WaitCycles - 1);
    localparam logic [15:0] GAP_LAST_C  = 16'(PollInterval - 1);
    localparam logic [15:0] MAX_POLLS_C = 16'(MaxPolls);

    localparam logic [7:0] ACG_CA_OUT_C  = 8'h08;
    localparam logic [7:0] ACG_DATA_IN_C = 8'h02;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LATCH   = 4'd1,
        S_CMD     = 4'd2,
        S_ADDR    = 4'd3,
        S_DATA    = 4'd4,
        S_EVAL    = 4'd5,
        S_GAP     = 4'd6,
        S_RECOVER = 4'd7,
        S_DONE    = 4'd8
    } state_e;

    // Bit 7 belongs to a primitive this command never uses.
    function automatic logic acg_all_ready(input logic [7:0] ready);
        return (ready[6:0] == 7'h7F);
    endfunction

    function automatic logic status_is_ready(input logic [7:0] status);
        return ((status & ReadyMask) == ReadyMask);
    endfunction

    state_e                  state_q, state_d;
    logic                    enhanced_q, enhanced_d;
    logic                    poll_mode_q, poll_mode_d;
    logic [23:0]             row_q, row_d;
    logic [NumberOfWays-1:0] way_q, way_d;
    logic [7:0]              status_q, status_d;
    logic [15:0]             poll_cnt_q, poll_cnt_d;
    logic [15:0]             timer_q, timer_d;
    logic                    issued_q, issued_d;
    logic                    timeout_q, timeout_d;

    logic                    start_s;
    logic                    cmd_active_s;
    logic [15:0]             poll_next_s;
    logic                    unused_ok_s;

    assign start_s      = (iOpcode == CommandID) && iCMDValid && (state_q == S_IDLE);
    assign cmd_active_s = issued_q || acg_all_ready(acg.iACG_Ready);
    assign poll_next_s  = (poll_cnt_q == 16'hFFFF) ? poll_cnt_q : (poll_cnt_q + 16'd1);
    assign unused_ok_s  = ^{iTargetID[4:2], acg.iACG_Ready[7], acg.iACG_LastStep[7:4],
                            acg.iACG_LastStep[2], acg.iACG_LastStep[0], acg.iACG_ReadData[15:8]};

    // State and context registers.
    always_ff @(posedge iSystemClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q     <= S_IDLE;
            enhanced_q  <= 1'b0;
            poll_mode_q <= 1'b0;
            row_q       <= 24'h000000;
            way_q       <= '0;
            status_q    <= 8'h00;
            poll_cnt_q  <= 16'h0000;
            timer_q     <= 16'h0000;
            issued_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            enhanced_q  <= enhanced_d;
            poll_mode_q <= poll_mode_d;
            row_q       <= row_d;
            way_q       <= way_d;
            status_q    <= status_d;
            poll_cnt_q  <= poll_cnt_d;
            timer_q     <= timer_d;
            issued_q    <= issued_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next-state and context update.
    always_comb begin
        state_d     = state_q;
        enhanced_d  = enhanced_q;
        poll_mode_d = poll_mode_q;
        row_d       = row_q;
        way_d       = way_q;
        status_d    = status_q;
        poll_cnt_d  = poll_cnt_q;
        timer_d     = timer_q;
        issued_d    = issued_q;
        timeout_d   = timeout_q;
        case (state_q)
            S_IDLE: begin
                // Command fields are taken on the accepting edge so they sit stable in LATCH.
                if (start_s) begin
                    state_d     = S_LATCH;
                    enhanced_d  = iTargetID[0];
                    poll_mode_d = iTargetID[1];
                    row_d       = iRowAddress;
                    way_d       = iWaySelect;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LATCH: begin
                poll_cnt_d = 16'h0000;
                timer_d    = 16'h0000;
                status_d   = 8'h00;
                issued_d   = 1'b0;
                timeout_d  = 1'b0;
                state_d    = S_CMD;
            end
            S_CMD: begin
                issued_d = cmd_active_s;
                if (cmd_active_s && acg.iACG_LastStep[3]) begin
                    issued_d = 1'b0;
                    state_d  = enhanced_q ? S_ADDR : S_DATA;
                end else begin
                    state_d = S_CMD;
                end
            end
            S_ADDR: begin
                issued_d = cmd_active_s;
                if (cmd_active_s && acg.iACG_LastStep[3]) begin
                    issued_d = 1'b0;
                    state_d  = S_DATA;
                end else begin
                    state_d = S_ADDR;
                end
            end
            S_DATA: begin
                issued_d = cmd_active_s;
                if (acg.iACG_ReadValid && acg.iACG_ReadLast) begin
                    status_d = acg.iACG_ReadData[7:0];
                end else begin
                    status_d = status_q;
                end
                if (cmd_active_s && acg.iACG_LastStep[1]) begin
                    issued_d = 1'b0;
                    state_d  = S_EVAL;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_EVAL: begin
                poll_cnt_d = poll_next_s;
                timer_d    = 16'h0000;
                // A ready status wins even on the last permitted poll.
                if (!poll_mode_q || status_is_ready(status_q)) begin
                    state_d = S_RECOVER;
                end else if (poll_next_s == MAX_POLLS_C) begin
                    timeout_d = 1'b1;
                    state_d   = S_RECOVER;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (timer_q == GAP_LAST_C) begin
                    timer_d = 16'h0000;
                    state_d = S_CMD;
                end else begin
                    timer_d = timer_q + 16'd1;
                    state_d = S_GAP;
                end
            end
            S_RECOVER: begin
                if (timer_q == WAIT_LAST_C) begin
                    timer_d = 16'h0000;
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_q + 16'd1;
                    state_d = S_RECOVER;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the registered state and latched context.
    always_comb begin
        oCMDReady              = (state_q == S_IDLE);
        oStart                 = start_s;
        oLastStep              = 1'b0;
        oStatus                = 24'h000000;
        oStatusValid           = 1'b0;
        oTimeout               = 1'b0;
        acg.oACG_Command       = 8'h00;
        acg.oACG_CommandOption = 3'b000;
        acg.oACG_NumOfData     = 16'h0000;
        acg.oACG_CASelect      = 1'b1;
        acg.oACG_CAData        = 40'h00_0000_0000;
        if (state_q == S_IDLE) begin
            acg.oACG_TargetWay = '0;
        end else begin
            acg.oACG_TargetWay = way_q;
        end
        case (state_q)
            S_CMD: begin
                acg.oACG_Command = cmd_active_s ? ACG_CA_OUT_C : 8'h00;
                acg.oACG_CAData  = {(enhanced_q ? 8'h78 : 8'h70), 32'h0000_0000};
            end
            S_ADDR: begin
                acg.oACG_Command   = cmd_active_s ? ACG_CA_OUT_C : 8'h00;
                acg.oACG_CASelect  = 1'b0;
                acg.oACG_NumOfData = 16'h0002;
                acg.oACG_CAData    = {row_q[7:0], row_q[15:8], row_q[23:16], 16'h0000};
            end
            S_DATA: begin
                acg.oACG_Command   = (cmd_active_s && !acg.iACG_LastStep[1]) ? ACG_DATA_IN_C : 8'h00;
                acg.oACG_CASelect  = 1'b0;
                acg.oACG_NumOfData = 16'h0002;
            end
            S_DONE: begin
                oLastStep    = 1'b1;
                oStatusValid = 1'b1;
                oTimeout     = timeout_q;
                oStatus      = {enhanced_q, timeout_q, 2'b00, row_q[18:7], status_q};
            end
            default: begin
                oLastStep = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_nfc_command_read_status_poll.sv
// Randomized bench for nfc_command_read_status_poll: the bench plays the ACG
// primitives and compares against a transaction-level model of the command.
module tb_nfc_command_read_status_poll;

    localparam int         NW     = 4;
    localparam logic [5:0] CMD_ID = 6'b001000;
    localparam int         WAIT_C = 5;
    localparam int         GAP_C  = 4;
    localparam int         MAXP_C = 3;
    localparam logic [7:0] MASK_C = 8'h40;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [5:0]    opcode;
    logic [4:0]    target_id;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [NW-1:0] way_sel;
    logic [23:0]   row_addr;
    logic          start;
    logic          last_step;
    logic [23:0]   status;
    logic          status_valid;
    logic          timeout;

    nfc_command_read_status_poll_if #(.NumberOfWays(NW)) acg_if ();

    nfc_command_read_status_poll #(
        .NumberOfWays(NW), .CommandID(CMD_ID), .WaitCycles(WAIT_C),
        .PollInterval(GAP_C), .MaxPolls(MAXP_C), .ReadyMask(MASK_C)
    ) dut (
        .iSystemClock(clk),   .iReset_n(rst_n),       .iOpcode(opcode),
        .iTargetID(target_id), .iCMDValid(cmd_valid), .oCMDReady(cmd_ready),
        .iWaySelect(way_sel), .iRowAddress(row_addr), .oStart(start),
        .oLastStep(last_step), .oStatus(status),      .oStatusValid(status_valid),
        .oTimeout(timeout),   .acg(acg_if)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] st_seq [8];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        check_eq({pfx, "_cmd_ready"}, cmd_ready, 1'b1);
        check_eq({pfx, "_start"}, start, 1'b0);
        check_eq({pfx, "_last_step"}, last_step, 1'b0);
        check_eq({pfx, "_status"}, status, 24'h0);
        check_eq({pfx, "_status_valid"}, status_valid, 1'b0);
        check_eq({pfx, "_timeout"}, timeout, 1'b0);
        check_eq({pfx, "_acg_cmd"}, acg_if.oACG_Command, 8'h00);
        check_eq({pfx, "_casel"}, acg_if.oACG_CASelect, 1'b1);
        check_eq({pfx, "_way"}, acg_if.oACG_TargetWay, '0);
        check_eq({pfx, "_nod"}, acg_if.oACG_NumOfData, 16'h0);
        check_eq({pfx, "_cadata"}, acg_if.oACG_CAData, 40'h0);
    endtask

    task automatic run_cmd(input bit enh, input bit poll, input logic [23:0] row,
                           input logic [NW-1:0] way, input bit abort_in_data);
        int          rounds;
        bit          exp_to;
        int          stall;
        bit          busy;
        bit          finished;
        logic [7:0]  op;
        int          done_cyc;
        int          last_data_cyc;
        int          data_seen;
        logic [23:0] exp_status;
        logic [39:0] ca_cmd;
        logic [39:0] ca_addr;
        logic [7:0]  lstep;
        logic [7:0]  q_cmd [$];
        logic [39:0] q_ca [$];
        logic        q_sel [$];
        logic [15:0] q_nod [$];

        // Reference: number of rounds and the final status from the poll rules.
        rounds = 1;
        exp_to = 1'b0;
        if (poll) begin
            for (int i = 0; i < MAXP_C; i++) begin
                rounds = i + 1;
                if ((st_seq[i] & MASK_C) == MASK_C) break;
            end
            exp_to = ((st_seq[rounds-1] & MASK_C) != MASK_C);
        end
        exp_status = {enh, exp_to, 2'b00, row[18:7], st_seq[rounds-1]};
        ca_cmd  = {(enh ? 8'h78 : 8'h70), 32'h0};
        ca_addr = {row[7:0], row[15:8], row[23:16], 16'h0};
        for (int r = 0; r < rounds; r++) begin
            q_cmd.push_back(8'h08); q_ca.push_back(ca_cmd); q_sel.push_back(1'b1); q_nod.push_back(16'h0);
            if (enh) begin
                q_cmd.push_back(8'h08); q_ca.push_back(ca_addr); q_sel.push_back(1'b0); q_nod.push_back(16'h2);
            end
            q_cmd.push_back(8'h02); q_ca.push_back(40'h0); q_sel.push_back(1'b0); q_nod.push_back(16'h2);
        end

        @(posedge clk); #1;
        opcode    = CMD_ID;
        target_id = {3'($urandom), poll, enh};
        row_addr  = row;
        way_sel   = way;
        cmd_valid = 1'b1;
        acg_if.iACG_Ready = {1'($urandom), 7'h7F};
        #1;
        check_eq("start_accept", start, 1'b1);

        stall = $urandom_range(0, 3);
        busy = 1'b0; finished = 1'b0; op = 8'h00; done_cyc = 0;
        last_data_cyc = -1; data_seen = 0;
        for (int k = 1; k <= 400 && !finished; k++) begin
            @(posedge clk); #1;
            cmd_valid = 1'($urandom);
            opcode    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : CMD_ID;
            if (k >= 2) begin
                target_id = 5'($urandom);
                row_addr  = 24'($urandom);
                way_sel   = NW'($urandom);
            end
            if (k <= 1 + stall) acg_if.iACG_Ready = {1'($urandom), 7'h00};
            else if (busy)      acg_if.iACG_Ready = {1'($urandom), 7'($urandom)};
            else                acg_if.iACG_Ready = {1'($urandom), 7'h7F};
            lstep = 8'($urandom) & 8'hF5;
            acg_if.iACG_ReadValid = 1'b0;
            acg_if.iACG_ReadLast  = 1'b0;
            acg_if.iACG_ReadData  = 16'($urandom);
            if (busy && k == done_cyc) begin
                if (op == 8'h08) begin
                    lstep[3] = 1'b1;
                end else begin
                    lstep[1] = 1'b1;
                    acg_if.iACG_ReadValid = 1'b1;
                    acg_if.iACG_ReadLast  = 1'b1;
                    acg_if.iACG_ReadData  = {8'($urandom), st_seq[data_seen]};
                end
            end else if (busy && op == 8'h02 && k == done_cyc - 1) begin
                acg_if.iACG_ReadValid = 1'b1;
            end
            acg_if.iACG_LastStep = lstep;
            #1;
            check_eq("start_busy", start, 1'b0);
            check_eq("cmd_ready_busy", cmd_ready, 1'b0);
            check_eq("target_way", acg_if.oACG_TargetWay, way);
            check_eq("cmd_option", acg_if.oACG_CommandOption, 3'b000);
            if (last_step) begin
                check_eq("done_latency", k - last_data_cyc, WAIT_C + 2);
                check_eq("status", status, exp_status);
                check_eq("status_valid", status_valid, 1'b1);
                check_eq("timeout", timeout, exp_to);
                check_eq("rounds", data_seen, rounds);
                check_eq("ops_left", q_cmd.size(), 0);
                finished = 1'b1;
            end else begin
                check_eq("no_status_valid", status_valid, 1'b0);
                check_eq("no_timeout", timeout, 1'b0);
            end
            if (busy) begin
                if (k == done_cyc && op == 8'h02) check_eq("data_drop", acg_if.oACG_Command, 8'h00);
                else                              check_eq("cmd_hold", acg_if.oACG_Command, op);
                if (k == done_cyc) begin
                    busy = 1'b0;
                    if (op == 8'h02) begin
                        last_data_cyc = k;
                        data_seen++;
                    end
                end
            end else if (acg_if.oACG_Command != 8'h00) begin
                if (q_cmd.size() == 0) begin
                    check_eq("extra_op", acg_if.oACG_Command, 8'h00);
                end else begin
                    if (q_sel[0]) begin
                        if (last_data_cyc < 0) check_eq("first_issue_cyc", k, 2 + stall);
                        else                   check_eq("poll_gap", k - last_data_cyc, GAP_C + 2);
                    end
                    check_eq("op_cmd", acg_if.oACG_Command, q_cmd[0]);
                    check_eq("op_casel", acg_if.oACG_CASelect, q_sel[0]);
                    check_eq("op_nod", acg_if.oACG_NumOfData, q_nod[0]);
                    if (q_cmd[0] == 8'h08) check_eq("op_cadata", acg_if.oACG_CAData, q_ca[0]);
                    op = q_cmd[0];
                    void'(q_cmd.pop_front()); void'(q_ca.pop_front());
                    void'(q_sel.pop_front()); void'(q_nod.pop_front());
                    busy = 1'b1;
                    done_cyc = k + $urandom_range(1, 3);
                    if (abort_in_data && op == 8'h02) begin
                        cmd_valid = 1'b0;
                        #1 rst_n = 1'b0;
                        #1;
                        check_reset_vals("rst_mid");
                        for (int j = 0; j < 3; j++) begin
                            @(posedge clk); #1;
                            check_eq("rst_no_last", last_step, 1'b0);
                            check_eq("rst_ready", cmd_ready, 1'b1);
                        end
                        acg_if.iACG_LastStep  = 8'h00;
                        acg_if.iACG_ReadValid = 1'b0;
                        @(negedge clk);
                        rst_n = 1'b1;
                        finished = 1'b1;
                    end
                end
            end
        end
        if (!finished) check_eq("cycle_budget", 1'b0, 1'b1);
        if (!abort_in_data) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            #1;
            check_eq("ready_after", cmd_ready, 1'b1);
            check_eq("single_last", last_step, 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0; opcode = 6'h0; target_id = 5'h0; cmd_valid = 1'b0;
        way_sel = '0; row_addr = 24'h0;
        acg_if.iACG_Ready = 8'h00; acg_if.iACG_LastStep = 8'h00;
        acg_if.iACG_ReadData = 16'h0; acg_if.iACG_ReadLast = 1'b0; acg_if.iACG_ReadValid = 1'b0;
        #12;
        check_reset_vals("por");
        @(negedge clk);
        rst_n = 1'b1;

        @(posedge clk); #1;
        opcode = CMD_ID ^ 6'b000001; cmd_valid = 1'b1;
        #1;
        check_eq("bad_opcode", start, 1'b0);

        st_seq[0] = 8'hE0;
        run_cmd(1'b0, 1'b0, 24'h000000, 4'b0001, 1'b0);
        st_seq[0] = 8'h1C;
        run_cmd(1'b1, 1'b0, 24'h012345, 4'b0100, 1'b0);
        st_seq[0] = 8'h00; st_seq[1] = 8'h00; st_seq[2] = 8'h40;
        run_cmd(1'b0, 1'b1, 24'h0ABCDE, 4'b0010, 1'b0);
        st_seq[0] = 8'h00; st_seq[1] = 8'h00; st_seq[2] = 8'h00;
        run_cmd(1'b0, 1'b1, 24'h7FFF80, 4'b1000, 1'b0);
        st_seq[0] = 8'hBF; st_seq[1] = 8'h3F; st_seq[2] = 8'hFF;
        run_cmd(1'b1, 1'b1, 24'hFEDCBA, 4'b0011, 1'b0);
        run_cmd(1'b0, 1'b1, 24'h135799, 4'b0101, 1'b1);

        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 8; i++) begin
                st_seq[i] = ($urandom_range(0, 3) == 0) ? (8'($urandom) | MASK_C)
                                                         : (8'($urandom) & ~MASK_C);
            end
            run_cmd(1'($urandom), 1'($urandom), 24'($urandom), NW'($urandom), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
